// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl
//   Host-side "Set LEDs" sequencer for the PS/2 keyboard path. It watches the
//   requested lock-key levels and, when they differ from the last target, sends
//   0xED followed by the LED mask. Each byte must be acknowledged with 0xFA.
//   A 0xFE reply or a missing ACK causes the byte to be sent again. While it waits
//   for an ACK, the controller takes over the receive FIFO.
//
//   Optional build macro: PS2_LED_INIT_EN. When it is defined, the controller
//   first resets the keyboard after clr: it sends 0xFF, waits for 0xFA and
//   then 0xAA. It then runs one unconditional Set-LEDs exchange.
//
// Ports
//   clk, clr            system clock, asynchronous active-high reset
//   caps_in/num_in/
//   scroll_in           requested LED levels
//   tx_data/tx_valid/
//   tx_ready            byte stream to the PS/2 transmitter (valid/ready)
//   rx_data/rx_ready    head of the PS/2 receive FIFO / FIFO not empty
//   rx_pop              one-cycle FIFO pop, only while rx_owned
//   rx_owned            controller owns the receive FIFO (ACK wait states)
//   led_state           last mask acknowledged by the keyboard {caps,num,scroll}
//   busy                high in every state except IDLE
//   err                 sticky abort flag, cleared by the next successful update
//
// State table
//   IDLE      | compare request with target, launch on difference
//   SEND_CMD  | present 0xED until accepted
//   WAIT_ACK1 | own rx FIFO, wait for ACK of 0xED
//   SEND_ARG  | present LED mask until accepted
//   WAIT_ACK2 | own rx FIFO, wait for ACK of the mask
//   INIT_SEND | (PS2_LED_INIT_EN) present 0xFF until accepted
//   INIT_ACK  | (PS2_LED_INIT_EN) wait for ACK of 0xFF
//   INIT_BAT  | (PS2_LED_INIT_EN) wait for BAT result 0xAA / 0xFC

module ps2_led_ctrl #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       caps_in,
  input  logic       num_in,
  input  logic       scroll_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_pop,
  output logic       rx_owned,
  output logic [2:0] led_state,
  output logic       busy,
  output logic       err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] KB_ACK      = 8'hFA;
  localparam logic [7:0] KB_RESEND   = 8'hFE;
`ifdef PS2_LED_INIT_EN
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] KB_BAT_OK   = 8'hAA;
  localparam logic [7:0] KB_BAT_FAIL = 8'hFC;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_ACK1,
    SEND_ARG,
    WAIT_ACK2
`ifdef PS2_LED_INIT_EN
    ,
    INIT_SEND,
    INIT_ACK,
    INIT_BAT
`endif
  } state_t;

`ifdef PS2_LED_INIT_EN
  localparam state_t RST_STATE = INIT_SEND;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t          state, state_n, retry_to;
  logic [2:0]      tgt, tgt_n, req, led_n;
  logic [TW-1:0]   timer, timer_n;
  logic [RW-1:0]   retry_cnt, retry_n;
  logic            err_n;
  logic            pop_q;
  logic            wait_st;
  logic            tmo_hit;
  logic            do_retry;

  assign req = {caps_in, num_in, scroll_in};

  always_comb begin
    wait_st = (state == WAIT_ACK1) || (state == WAIT_ACK2);
`ifdef PS2_LED_INIT_EN
    if ((state == INIT_ACK) || (state == INIT_BAT)) wait_st = 1'b1;
`endif
  end

  assign rx_owned = wait_st;
  // pop_q blocks back-to-back pops so the FIFO head has a cycle to advance.
  assign rx_pop   = wait_st & rx_ready & ~pop_q;
  assign busy     = (state != IDLE);
  // A byte at the FIFO head takes priority over an expiring timer. The timer
  // saturates, so the timeout is taken on the next cycle if the byte was stray.
  assign tmo_hit  = wait_st & ~rx_ready & (timer == TMO_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= RST_STATE;
      tgt       <= 3'b000;
      timer     <= '0;
      retry_cnt <= '0;
      led_state <= 3'b000;
      err       <= 1'b0;
      pop_q     <= 1'b0;
    end else begin
      state     <= state_n;
      tgt       <= tgt_n;
      timer     <= timer_n;
      retry_cnt <= retry_n;
      led_state <= led_n;
      err       <= err_n;
      pop_q     <= rx_pop;
    end
  end

  always_comb begin
    state_n  = state;
    tgt_n    = tgt;
    timer_n  = timer;
    retry_n  = retry_cnt;
    led_n    = led_state;
    err_n    = err;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    do_retry = 1'b0;
    retry_to = state;

    if (wait_st && (timer != TMO_LAST)) timer_n = timer + 1'b1;

    case (state)
      IDLE: begin
        if (req != tgt) begin
          tgt_n   = req;
          retry_n = '0;
          state_n = SEND_CMD;
        end
      end
      SEND_CMD: begin
        tx_valid = 1'b1;
        tx_data  = CMD_SET_LED;
        if (tx_ready) begin
          timer_n = '0;
          state_n = WAIT_ACK1;
        end
      end
      WAIT_ACK1: begin
        retry_to = SEND_CMD;
        if (rx_pop) begin
          if (rx_data == KB_ACK) begin
            retry_n = '0;
            state_n = SEND_ARG;
          end else if (rx_data == KB_RESEND) begin
            do_retry = 1'b1;
          end
        end else if (tmo_hit) begin
          do_retry = 1'b1;
        end
      end
      SEND_ARG: begin
        tx_valid = 1'b1;
        tx_data  = {5'b00000, tgt};
        if (tx_ready) begin
          timer_n = '0;
          state_n = WAIT_ACK2;
        end
      end
      WAIT_ACK2: begin
        retry_to = SEND_ARG;
        if (rx_pop) begin
          if (rx_data == KB_ACK) begin
            led_n   = tgt;
            err_n   = 1'b0;
            retry_n = '0;
            state_n = IDLE;
          end else if (rx_data == KB_RESEND) begin
            do_retry = 1'b1;
          end
        end else if (tmo_hit) begin
          do_retry = 1'b1;
        end
      end
`ifdef PS2_LED_INIT_EN
      INIT_SEND: begin
        tx_valid = 1'b1;
        tx_data  = CMD_RESET;
        if (tx_ready) begin
          timer_n = '0;
          state_n = INIT_ACK;
        end
      end
      INIT_ACK: begin
        retry_to = INIT_SEND;
        if (rx_pop) begin
          if (rx_data == KB_ACK) begin
            timer_n = '0;
            state_n = INIT_BAT;
          end else if (rx_data == KB_RESEND) begin
            do_retry = 1'b1;
          end
        end else if (tmo_hit) begin
          do_retry = 1'b1;
        end
      end
      INIT_BAT: begin
        retry_to = INIT_SEND;
        if (rx_pop) begin
          if (rx_data == KB_BAT_OK) begin
            // Unconditional LED sync with whatever the inputs say right now.
            tgt_n   = req;
            retry_n = '0;
            state_n = SEND_CMD;
          end else if (rx_data == KB_BAT_FAIL) begin
            err_n   = 1'b1;
            retry_n = '0;
            state_n = IDLE;
          end else if (rx_data == KB_RESEND) begin
            do_retry = 1'b1;
          end
        end else if (tmo_hit) begin
          do_retry = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // On exhaustion tgt keeps the failed value, so IDLE stays quiet until the
    // request changes again.
    if (do_retry) begin
      if (retry_cnt == RETRY_LAST) begin
        err_n   = 1'b1;
        retry_n = '0;
        state_n = IDLE;
      end else begin
        retry_n = retry_cnt + 1'b1;
        state_n = retry_to;
      end
    end
  end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Scoreboard bench for ps2_led_ctrl. Each test pushes its expected transmit bytes
// into exp_q and the keyboard replies into resp_q. A single monitor/keyboard
// process checks every accepted tx byte against exp_q and answers each one from
// resp_q through a small receive FIFO model.
module tb_ps2_led_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       caps_in = 1'b0, num_in = 1'b0, scroll_in = 1'b0;
  logic       tx_ready = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid, rx_pop, rx_owned, busy, err;
  logic [2:0] led_state;

  int total = 0, bad = 0;
  int cyc = 0, pop_cnt = 0, last_pop_cyc = 0, idle_cyc = 0;
  logic [7:0] exp_q[$];
  int         resp_q[$];   // -1: no reply, <256: one byte, else {stray, byte}
  int         xfer_cyc[$];
  logic [7:0] rx_q[$];
  logic [7:0] pend_q[$];
  bit         pend_pop = 1'b0;
  bit         flush = 1'b0;

  ps2_led_ctrl #(.TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
    .clk(clk), .clr(clr),
    .caps_in(caps_in), .num_in(num_in), .scroll_in(scroll_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_pop(rx_pop), .rx_owned(rx_owned),
    .led_state(led_state), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  // Monitor and keyboard model. It samples handshakes on the negedge and applies
  // the resulting FIFO changes just after the following posedge.
  always begin
    @(negedge clk);
    if (!clr) begin
      if (tx_valid && tx_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("tx_unexpected", int'(tx_data), 256);
        end else begin
          check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
        if (resp_q.size() != 0) begin
          int r;
          r = resp_q.pop_front();
          if (r >= 256) begin
            pend_q.push_back(r[15:8]);
            pend_q.push_back(r[7:0]);
          end else if (r >= 0) begin
            pend_q.push_back(r[7:0]);
          end
        end
      end
      if (rx_pop) begin
        check("pop_owned", int'(rx_owned), 1);
        pend_pop = 1'b1;
        pop_cnt++;
        last_pop_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_pop && rx_q.size() != 0) void'(rx_q.pop_front());
    pend_pop = 1'b0;
    while (pend_q.size() != 0) rx_q.push_back(pend_q.pop_front());
    if (flush) begin
      rx_q.delete();
      pend_q.delete();
    end
    rx_ready = (rx_q.size() != 0);
    rx_data  = rx_ready ? rx_q[0] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    check({name, "_start"}, int'(busy), 1);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    check({name, "_done"}, int'(busy), 0);
    idle_cyc = cyc;
  endtask

  task automatic wait_owned(input string name);
    int n;
    n = 0;
    while (!rx_owned && n < 50) begin @(negedge clk); n++; end
    check({name, "_owned"}, int'(rx_owned), 1);
  endtask

  initial begin
    int p0, hold_busy, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_owned", int'(rx_owned), 0);
    check("rst_pop", int'(rx_pop), 0);
    check("rst_led", int'(led_state), 0);
    check("rst_err", int'(err), 0);
    tick(1);
    clr = 1'b0;
    tick(3);
    check("post_rst_busy", int'(busy), 0);

    // Caps toggle
    exp_q.push_back(8'hED); exp_q.push_back(8'h04);
    resp_q.push_back('hFA); resp_q.push_back('hFA);
    caps_in = 1'b1;
    wait_done("caps");
    check("caps_led", int'(led_state), 3'b100);
    check("caps_err", int'(err), 0);
    check("caps_idle_lat", idle_cyc - last_pop_cyc, 1);
    check("caps_drain", exp_q.size(), 0);

    // Caps off
    tick(1);
    exp_q.push_back(8'hED); exp_q.push_back(8'h00);
    resp_q.push_back('hFA); resp_q.push_back('hFA);
    caps_in = 1'b0;
    wait_done("off");
    check("off_led", int'(led_state), 3'b000);

    // Resend on the command byte
    tick(1);
    exp_q.push_back(8'hED); exp_q.push_back(8'hED); exp_q.push_back(8'h04);
    resp_q.push_back('hFE); resp_q.push_back('hFA); resp_q.push_back('hFA);
    caps_in = 1'b1;
    wait_done("resend");
    check("resend_led", int'(led_state), 3'b100);
    check("resend_drain", exp_q.size(), 0);

    // Stray byte while waiting for the first ACK
    tick(1);
    p0 = pop_cnt;
    exp_q.push_back(8'hED); exp_q.push_back(8'h02);
    resp_q.push_back('h1CFA); resp_q.push_back('hFA);
    caps_in = 1'b0; num_in = 1'b1;
    wait_done("stray");
    check("stray_led", int'(led_state), 3'b010);
    check("stray_pops", pop_cnt - p0, 3);
    check("stray_owned_idle", int'(rx_owned), 0);

    // Back to all-off
    tick(1);
    exp_q.push_back(8'hED); exp_q.push_back(8'h00);
    resp_q.push_back('hFA); resp_q.push_back('hFA);
    num_in = 1'b0;
    wait_done("clear");
    check("clear_led", int'(led_state), 3'b000);

    // Request changes mid-transaction
    tick(1);
    exp_q.push_back(8'hED); exp_q.push_back(8'h04);
    exp_q.push_back(8'hED); exp_q.push_back(8'h06);
    repeat (4) resp_q.push_back('hFA);
    caps_in = 1'b1;
    wait_owned("mid");
    num_in = 1'b1;
    wait_done("mid_first");
    check("mid_first_led", int'(led_state), 3'b100);
    wait_done("mid_second");
    check("mid_second_led", int'(led_state), 3'b110);
    check("mid_drain", exp_q.size(), 0);

    // Timeout exhaustion, with no replies at all
    tick(1);
    xfer_cyc.delete();
    repeat (3) exp_q.push_back(8'hED);
    scroll_in = 1'b1;
    wait_done("tmo");
    check("tmo_err", int'(err), 1);
    check("tmo_led", int'(led_state), 3'b110);
    check("tmo_sends", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      check("tmo_gap1", xfer_cyc[1] - xfer_cyc[0], 17);
      check("tmo_gap2", xfer_cyc[2] - xfer_cyc[1], 17);
    end
    hold_busy = 0;
    repeat (40) begin @(negedge clk); if (busy) hold_busy++; end
    check("tmo_stays_idle", hold_busy, 0);
    check("tmo_err_sticky", int'(err), 1);

    // Recovery, including a resend of the mask byte; err must clear
    tick(1);
    exp_q.push_back(8'hED); exp_q.push_back(8'h06); exp_q.push_back(8'h06);
    resp_q.push_back('hFA); resp_q.push_back('hFE); resp_q.push_back('hFA);
    scroll_in = 1'b0;
    wait_done("recover");
    check("recover_led", int'(led_state), 3'b110);
    check("recover_err", int'(err), 0);
    check("recover_drain", exp_q.size(), 0);

    // Async reset while the mask is stalled in SEND_ARG
    tick(1);
    exp_q.push_back(8'hED);
    resp_q.push_back('hFA);
    caps_in = 1'b0;
    wait_owned("arst");
    tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    check("arst_arg_valid", int'(tx_valid), 1);
    check("arst_arg_data", int'(tx_data), 8'h02);
    #2;
    clr = 1'b1;
    #1;
    check("arst_tx_valid", int'(tx_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_owned", int'(rx_owned), 0);
    check("arst_led", int'(led_state), 0);
    flush = 1'b1;
    num_in = 1'b0;
    tx_ready = 1'b1;
    tick(3);
    clr = 1'b0;
    flush = 1'b0;
    hold_busy = 0;
    repeat (10) begin @(negedge clk); if (busy) hold_busy++; end
    check("arst_quiet", hold_busy, 0);
    check("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
